fifo_serial_tx: RTL
===================

FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10: width of each FIFO word and of each serial data field.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: CLK cycles per serial bit; legal range 2..65535.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Empty  input  1  FIFO empty flag from the FIFO being drained.
REQ-006 SHALL have port Fifo_Dout  input  DATA_WIDTH  FIFO read data, valid on the cycle after RD_EN is sampled.
REQ-007 SHALL have port RD_EN  output  1  FIFO pop strobe, one cycle per word.
REQ-008 SHALL have port TX  output  1  serial line, idle high.
REQ-009 SHALL have port Busy  output  1  high whenever the FSM is not IDLE.
REQ-010 SHALL have port Frame_Done  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-012 IDLE -> FETCH when Empty sampled 0; otherwise stays IDLE, TX=1.
REQ-013 FETCH lasts exactly one cycle with RD_EN=1; RD_EN SHALL be 0 in every other state.
REQ-014 LOAD lasts one cycle; at its end Fifo_Dout SHALL be captured into the shift register; next state START.
REQ-015 START drives TX=0 for CLKS_PER_BIT cycles; next DATA.
REQ-016 DATA shifts out DATA_WIDTH bits LSB first, each held CLKS_PER_BIT cycles; bit counter width clog2(DATA_WIDTH+1).
REQ-017 After the last data bit, next state is PARITY if enabled (REQ-025), else STOP.
REQ-018 STOP drives TX=1 for CLKS_PER_BIT cycles; Frame_Done=1 on its final cycle.
REQ-019 STOP exit: to FETCH if Empty=0 on the final STOP cycle (back-to-back frames, no idle gap), else to IDLE.
REQ-020 RD_EN SHALL never assert unless Empty was sampled 0 in the preceding cycle; exactly one pop per transmitted frame.
REQ-021 Changes of Empty or Fifo_Dout outside FETCH/LOAD SHALL not affect the frame in progress.
REQ-022 Latency: first TX falling edge 3 cycles after Empty is first sampled 0 in IDLE (FETCH, LOAD, then START).

Reset
REQ-023 On RST=1, immediately and independent of CLK: state IDLE, TX=1, RD_EN=0, Busy=0, Frame_Done=0, all counters and shift register zero.
REQ-024 Reset mid-frame SHALL abort the frame; a word already popped is discarded; after RST falls, operation resumes per REQ-012.

Configuration
REQ-025 Macro FIFO_SERIAL_TX_PARITY_EN defined: PARITY state inserted after DATA, TX = even parity (XOR of the data bits) for CLKS_PER_BIT cycles; frame = DATA_WIDTH+3 bits.
REQ-026 Macro undefined: PARITY state and logic absent; frame = DATA_WIDTH+2 bits.

Structure
REQ-027 Package fifo_serial_tx_pkg SHALL hold the FSM state typedef and the idle/start/stop line-level constants.
REQ-028 Sub-module baud_tick_gen SHALL hold the CLKS_PER_BIT divider, restarted at each START entry, issuing one end-of-bit tick per bit period.

Verification (DATA_WIDTH=10, CLKS_PER_BIT=4)
REQ-029 Reset: RST pulse mid-DATA -> TX=1, Busy=0, RD_EN=0 in the same cycle, no further pop until Empty=0 after release.
REQ-030 Single word 10'h2A5, parity off: one RD_EN pulse; TX = 0,1,0,1,0,0,1,0,1,0,1,1 bits, 4 cycles each, 48 cycles; one Frame_Done.
REQ-031 Same word, FIFO_SERIAL_TX_PARITY_EN defined: parity bit 1 before stop; frame 52 cycles.
REQ-032 Three words queued (Empty=0 throughout): three RD_EN pulses, frames separated only by FETCH+LOAD (2 cycles), Busy stays 1.
REQ-033 Empty=1 forever: RD_EN, Busy, Frame_Done stay 0 and TX stays 1 for 1000 cycles.
REQ-034 Empty toggles during DATA: no extra RD_EN, transmitted bits unchanged.

Source files
------------

// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and line levels for the FIFO-draining serial transmitter.
// Optional parity stage enabled by defining FIFO_SERIAL_TX_PARITY_EN.
package fifo_serial_tx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StLoad   = 3'd2,
    StStart  = 3'd3,
    StData   = 3'd4,
`ifdef FIFO_SERIAL_TX_PARITY_EN
    StParity = 3'd5,
`endif
    StStop   = 3'd6
  } tx_state_e;

  localparam logic LineIdle  = 1'b1;
  localparam logic LineStart = 1'b0;
  localparam logic LineStop  = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period divider: one end-of-bit tick every CLKS_PER_BIT enabled cycles,
// restartable so each frame's START bit begins a fresh period.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CntMax);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from a FIFO and sends each as a start/data/stop serial frame.
// Define FIFO_SERIAL_TX_PARITY_EN to insert an even-parity bit before stop.
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 10,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Empty,
  input  logic [DATA_WIDTH-1:0] Fifo_Dout,
  output logic                  RD_EN,
  output logic                  TX,
  output logic                  Busy,
  output logic                  Frame_Done
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  tx_state_e             r_state;
  tx_state_e             w_state_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BitCntW-1:0]    r_bit_cnt;
  logic                  w_tick;
  logic                  w_bit_en;
  logic                  w_restart;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic                  r_parity;
`endif

  // Divider restarts during LOAD so START always gets a full bit period.
  assign w_restart = (r_state == StLoad);
  assign w_bit_en  = (r_state != StIdle) && (r_state != StFetch) && (r_state != StLoad);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_restart(w_restart),
    .i_en     (w_bit_en),
    .o_tick   (w_tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (!Empty) w_state_next = StFetch;
      StFetch: w_state_next = StLoad;
      StLoad:  w_state_next = StStart;
      StStart: if (w_tick) w_state_next = StData;
      StData: begin
        if (w_tick && (r_bit_cnt == LastBit)) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
          w_state_next = StParity;
`else
          w_state_next = StStop;
`endif
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      StParity: if (w_tick) w_state_next = StStop;
`endif
      StStop:  if (w_tick) w_state_next = Empty ? StIdle : StFetch;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (r_state == StLoad) begin
      r_shift   <= Fifo_Dout;
      r_bit_cnt <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      r_parity  <= ^Fifo_Dout;
`endif
    end else if ((r_state == StData) && w_tick) begin
      r_shift   <= r_shift >> 1;
      r_bit_cnt <= r_bit_cnt + BitCntW'(1);
    end
  end

  always_comb begin
    RD_EN      = 1'b0;
    TX         = LineIdle;
    Busy       = (r_state != StIdle);
    Frame_Done = 1'b0;
    case (r_state)
      StFetch: RD_EN = 1'b1;
      StStart: TX = LineStart;
      StData:  TX = r_shift[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
      StParity: TX = r_parity;
`endif
      StStop: begin
        TX         = LineStop;
        Frame_Done = w_tick;
      end
      default: ;
    endcase
  end

endmodule
